bc_result_display: RTL and testbench

Output-side sequencer for the bulls-and-cows game: accepts one scored guess per handshake and plays it out on the single seven-segment digit as a timed glyph sequence. Sequence: `b`, bulls count, `C`, cows count, then blank; or a flashing `8.` on a win. Sits between the scoring logic and `uo_out`. It is the display-direction counterpart of the synchronised input/save-pulse path.

---
 rtl/bc_pkg.sv | 58 +++++
 rtl/bc_seg7_encoder.sv | 25 ++
 rtl/bc_result_display.sv | 181 ++++++++++++++++++
 tb/tb_bc_result_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// bc_pkg: shared types and seven-segment constants for the
// bulls-and-cows result display (states, glyph selects, patterns).
package bc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B_LBL,
    ST_B_VAL,
    ST_C_LBL,
    ST_C_VAL,
    ST_GAP,
    ST_ERR,
    ST_WIN_ON,
    ST_WIN_OFF
  } state_e;

  typedef enum logic [2:0] {
    GL_DASH,
    GL_B,
    GL_C,
    GL_E,
    GL_ALL,
    GL_BLANK,
    GL_DIGIT
  } glyph_e;

  localparam logic [7:0] SEG_DASH   = 8'h40;
  localparam logic [7:0] SEG_B      = 8'h7C;
  localparam logic [7:0] SEG_C      = 8'h39;
  localparam logic [7:0] SEG_E      = 8'h79;
  localparam logic [7:0] SEG_ALL_DP = 8'hFF;
  localparam logic [7:0] SEG_BLANK  = 8'h00;

  localparam logic [7:0] SEG_D0 = 8'h3F;
  localparam logic [7:0] SEG_D1 = 8'h06;
  localparam logic [7:0] SEG_D2 = 8'h5B;
  localparam logic [7:0] SEG_D3 = 8'h4F;
  localparam logic [7:0] SEG_D4 = 8'h66;

  localparam int MAX_PEGS = 4;

  function automatic logic [7:0] digit_seg(
    input logic [2:0] d
  );
    logic [7:0] s;
    s = SEG_BLANK;
    case (d)
      3'd0:    s = SEG_D0;
      3'd1:    s = SEG_D1;
      3'd2:    s = SEG_D2;
      3'd3:    s = SEG_D3;
      3'd4:    s = SEG_D4;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bc_seg7_encoder.sv
// bc_seg7_encoder: combinational glyph/digit to segment pattern.
// Ports: glyph (select), digit (0-4), seg (bit0=a..bit6=g, bit7=dp).
module bc_seg7_encoder
  import bc_pkg::*;
(
  input  glyph_e      glyph,
  input  logic [2:0]  digit,
  output logic [7:0]  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      GL_DASH:  seg = SEG_DASH;
      GL_B:     seg = SEG_B;
      GL_C:     seg = SEG_C;
      GL_E:     seg = SEG_E;
      GL_ALL:   seg = SEG_ALL_DP;
      GL_BLANK: seg = SEG_BLANK;
      GL_DIGIT: seg = digit_seg(digit);
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bc_result_display.sv
// bc_result_display: plays one scored guess on the 7-seg digit as
// b, bulls, C, cows, blank; E on bad input; flashing 8. on a win.
// Ports: clk, rst_n (sync, active-low), res_valid/res_ready
// handshake with res_bulls/res_cows/res_win, segment_out, busy.
// Option: BC_DISP_HEARTBEAT_EN blinks dp while idle.
module bc_result_display
  import bc_pkg::*;
#(
  parameter int DWELL_CYCLES = 5_000_000,
  parameter int WIN_FLASHES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [2:0]  res_bulls,
  input  logic [2:0]  res_cows,
  input  logic        res_win,
  output logic [7:0]  segment_out,
  output logic        busy
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam int FW = $clog2(WIN_FLASHES + 1);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(DWELL_CYCLES - 1);
  localparam logic [FW-1:0] FL_LAST =
    FW'(WIN_FLASHES);
  localparam logic [3:0] PEG_LIM = 4'(MAX_PEGS);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]  fl_q, fl_d, fl_inc;
  logic [2:0]     bulls_q, cows_q;
  logic [7:0]     seg_q, seg_d, enc_seg;
  glyph_e         gsel;
  logic [2:0]     gdig;
  logic           take, dwell_done, bad;
  logic           dp_d;
  logic [3:0]     sum;

`ifdef BC_DISP_HEARTBEAT_EN
  logic           hb_q, hb_d;
`endif

  assign res_ready   = (state_q == ST_IDLE);
  assign busy        = ~res_ready;
  assign segment_out = seg_q;

  assign take       = res_valid & res_ready;
  assign dwell_done = (cnt_q == CNT_LAST);
  assign fl_inc     = fl_q + 1'b1;

  // 4-bit sum so 4+4 and 7+7 cannot wrap below the limit
  assign sum = {1'b0, res_bulls} + {1'b0, res_cows};
  assign bad = ({1'b0, res_bulls} > PEG_LIM) |
               ({1'b0, res_cows} > PEG_LIM) |
               (sum > PEG_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    fl_d    = fl_q;
`ifdef BC_DISP_HEARTBEAT_EN
    hb_d    = hb_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef BC_DISP_HEARTBEAT_EN
        cnt_d = dwell_done ? '0 : cnt_q + 1'b1;
        if (dwell_done) hb_d = ~hb_q;
`else
        cnt_d = '0;
`endif
        if (take) begin
          fl_d = '0;
          if (bad)          state_d = ST_ERR;
          else if (res_win) state_d = ST_WIN_ON;
          else              state_d = ST_B_LBL;
        end
      end
      ST_B_LBL:
        if (dwell_done) state_d = ST_B_VAL;
      ST_B_VAL:
        if (dwell_done) state_d = ST_C_LBL;
      ST_C_LBL:
        if (dwell_done) state_d = ST_C_VAL;
      ST_C_VAL:
        if (dwell_done) state_d = ST_GAP;
      ST_GAP:
        if (dwell_done) state_d = ST_IDLE;
      ST_ERR:
        if (dwell_done) state_d = ST_IDLE;
      ST_WIN_ON:
        if (dwell_done) state_d = ST_WIN_OFF;
      ST_WIN_OFF: begin
        if (dwell_done) begin
          if (fl_inc == FL_LAST) begin
            state_d = ST_IDLE;
            fl_d    = '0;
          end else begin
            state_d = ST_WIN_ON;
            fl_d    = fl_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // every state entry restarts the dwell
    if (state_d != state_q) begin
      cnt_d = '0;
`ifdef BC_DISP_HEARTBEAT_EN
      hb_d  = 1'b0;
`endif
    end
  end

  // glyph follows the next state so the pattern register
  // changes on the same edge as the state register
  always_comb begin
    gsel = GL_DASH;
    gdig = cows_q;
    case (state_d)
      ST_IDLE:    gsel = GL_DASH;
      ST_B_LBL:   gsel = GL_B;
      ST_B_VAL: begin
        gsel = GL_DIGIT;
        gdig = bulls_q;
      end
      ST_C_LBL:   gsel = GL_C;
      ST_C_VAL:   gsel = GL_DIGIT;
      ST_GAP:     gsel = GL_BLANK;
      ST_ERR:     gsel = GL_E;
      ST_WIN_ON:  gsel = GL_ALL;
      ST_WIN_OFF: gsel = GL_BLANK;
      default:    gsel = GL_DASH;
    endcase
  end

`ifdef BC_DISP_HEARTBEAT_EN
  assign dp_d = (state_d == ST_IDLE) & hb_d;
`else
  assign dp_d = 1'b0;
`endif

  bc_seg7_encoder u_enc (
    .glyph (gsel),
    .digit (gdig),
    .seg   (enc_seg)
  );

  assign seg_d = enc_seg | {dp_d, 7'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fl_q    <= '0;
      bulls_q <= '0;
      cows_q  <= '0;
      seg_q   <= SEG_DASH;
`ifdef BC_DISP_HEARTBEAT_EN
      hb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      seg_q   <= seg_d;
`ifdef BC_DISP_HEARTBEAT_EN
      hb_q    <= hb_d;
`endif
      if (take) begin
        bulls_q <= res_bulls;
        cows_q  <= res_cows;
      end
    end
  end

endmodule

// File: tb/tb_bc_result_display.sv
// tb_bc_result_display: directed stimulus, per-cycle compare
// against a glyph-queue model, plus literal spot checks.
module tb_bc_result_display;

  localparam int D  = 4;
  localparam int WF = 3;

  logic       clk;
  logic       rst_n;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_bulls;
  logic [2:0] res_cows;
  logic       res_win;
  logic [7:0] segment_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bc_result_display #(
    .DWELL_CYCLES (D),
    .WIN_FLASHES  (WF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_bulls   (res_bulls),
    .res_cows    (res_cows),
    .res_win     (res_win),
    .segment_out (segment_out),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] dig_tab [0:4] =
    '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};

  logic [7:0] q[$];
  logic [7:0] exp_seg = 8'h40;
  bit         exp_rdy = 1'b1;
  int         idle_n  = 0;
  bit         mdl_on  = 1'b0;

  function automatic logic [7:0] idle_glyph(input int n);
`ifdef BC_DISP_HEARTBEAT_EN
    return (((n / D) % 2) != 0) ? 8'hC0 : 8'h40;
`else
    return 8'h40;
`endif
  endfunction

  task automatic put(input logic [7:0] g);
    for (int i = 0; i < D; i++) q.push_back(g);
  endtask

  task automatic build(
    input int b,
    input int c,
    input bit w
  );
    if (b > 4 || c > 4 || b + c > 4) begin
      put(8'h79);
    end else if (w) begin
      for (int k = 0; k < WF; k++) begin
        put(8'hFF);
        put(8'h00);
      end
    end else begin
      put(8'h7C);
      put(dig_tab[b]);
      put(8'h39);
      put(dig_tab[c]);
      put(8'h00);
    end
  endtask

  always @(posedge clk) begin : model
    logic [7:0] s;
    bit         r;
    int         n;
    s = exp_seg;
    r = exp_rdy;
    n = idle_n;
    if (!rst_n) begin
      q.delete();
      s = 8'h40;
      r = 1'b1;
      n = 1;
    end else begin
      if (r && res_valid)
        build(int'(res_bulls), int'(res_cows), res_win);
      if (q.size() > 0) begin
        s = q.pop_front();
        r = 1'b0;
      end else if (!r) begin
        s = idle_glyph(0);
        r = 1'b1;
        n = 1;
      end else begin
        s = idle_glyph(n);
        n = n + 1;
      end
    end
    exp_seg <= s;
    exp_rdy <= r;
    idle_n  <= n;
    mdl_on  <= 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("seg", int'(segment_out), int'(exp_seg));
      chk("ready", int'(res_ready), int'(exp_rdy));
      chk("busy", int'(busy), int'(!exp_rdy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(
    input  logic [2:0] b,
    input  logic [2:0] c,
    input  logic       w,
    output int         n
  );
    n = 0;
    res_bulls = b;
    res_cows  = c;
    res_win   = w;
    res_valid = 1'b1;
    while (!res_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("handshake_timeout", n, 0);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!res_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", n, 0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_bulls = 3'd0;
    res_cows  = 3'd0;
    res_win   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_ready", int'(res_ready), 1);
    chk("rst_busy", int'(busy), 0);
    for (int i = 0; i < 12; i++) begin
`ifdef BC_DISP_HEARTBEAT_EN
      chk("idle_hb", int'(segment_out),
          ((i / 4) % 2) != 0 ? 32'hC0 : 32'h40);
`else
      chk("idle", int'(segment_out), 32'h40);
`endif
      @(negedge clk);
    end

    send(3'd1, 3'd2, 1'b0, n);
    chk("norm_first", int'(segment_out), 32'h7C);
    wait_ready(n);
    chk("norm_len", n, 20);

    send(3'd4, 3'd0, 1'b1, n);
    chk("win_first", int'(segment_out), 32'hFF);
    wait_ready(n);
    chk("win_len", n, 24);

    send(3'd3, 3'd2, 1'b0, n);
    chk("err_sum", int'(segment_out), 32'h79);
    wait_ready(n);
    chk("err_len", n, 4);

    send(3'd5, 3'd0, 1'b0, n);
    chk("err_b5", int'(segment_out), 32'h79);
    wait_ready(n);

    send(3'd2, 3'd2, 1'b0, n);
    chk("sum4_ok", int'(segment_out), 32'h7C);
    wait_ready(n);

    send(3'd2, 3'd1, 1'b0, n);
    repeat (4) @(negedge clk);
    chk("bval", int'(segment_out), 32'h5B);
    res_bulls = 3'd0;
    res_cows  = 3'd3;
    res_win   = 1'b1;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    chk("pulse_ign", int'(segment_out), 32'h5B);
    send(3'd3, 3'd1, 1'b0, n);
    chk("held_wait", n, 14);
    chk("held_first", int'(segment_out), 32'h7C);
    wait_ready(n);

    send(3'd1, 3'd1, 1'b0, n);
    repeat (8) @(negedge clk);
    chk("clbl", int'(segment_out), 32'h39);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_seg", int'(segment_out), 32'h40);
    chk("mid_rst_rdy", int'(res_ready), 1);
    rst_n = 1'b1;

    send(3'd0, 3'd4, 1'b0, n);
    chk("after_rst", int'(segment_out), 32'h7C);
    wait_ready(n);
    chk("after_rst_len", n, 20);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
